// File: rtl/noc_buf_pkg.sv
// noc_buf_pkg: shared width rules and defaults for the router input buffers
package noc_buf_pkg;
  localparam int FLIT_W = 16;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v >>= 1) r++;
    return r;
  endfunction
  function automatic int vc_width(input int n);
    return n > 1 ? clog2(n) : 1;
  endfunction
endpackage

// File: rtl/vc_fifo_ctrl.sv
// vc_fifo_ctrl: occupancy, pointers, status and sticky errors of one virtual channel
module vc_fifo_ctrl import noc_buf_pkg::*; #(
  parameter int DEPTH = 8,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int PW = clog2(DEPTH),
  parameter int CW = clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_req,
  input  logic          rd_req,
  input  logic          err_clr,
  output logic          wr_acc,
  output logic          rd_acc,
  output logic [PW-1:0] wr_ptr,
  output logic [PW-1:0] rd_ptr,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full,
  output logic          almost_full,
  output logic          err_ovf,
  output logic          err_udf
);
  // status comes straight from the count; acceptance ignores same-cycle activity on the other port
  always_comb begin
    empty = count == '0;
    full = count == CW'(DEPTH);
    almost_full = count >= CW'(AF_LEVEL);
    wr_acc = wr_req && !full;
    rd_acc = rd_req && !empty;
  end
  // pointers wrap naturally at DEPTH; a set event outranks a same-cycle clear
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      err_ovf <= 1'b0;
      err_udf <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + PW'(wr_acc);
      rd_ptr <= rd_ptr + PW'(rd_acc);
      count <= count + CW'(wr_acc) - CW'(rd_acc);
      err_ovf <= (wr_req && full) || (err_ovf && !err_clr);
      err_udf <= (rd_req && empty) || (err_udf && !err_clr);
    end
  end
endmodule

// File: rtl/vc_input_buffer.sv
// vc_input_buffer: multi-VC input buffer with shared storage and registered read port
module vc_input_buffer import noc_buf_pkg::*; #(
  parameter int NUM_BITS = FLIT_W,
  parameter int DEPTH = 8,
  parameter int NUM_VC = 4,
  parameter int AF_LEVEL = DEPTH - 2,
  localparam int VCW = vc_width(NUM_VC),
  localparam int PW = clog2(DEPTH),
  localparam int CW = clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_en,
  input  logic [VCW-1:0]       wr_vc,
  input  logic [NUM_BITS-1:0]  fifo_in,
  input  logic                 rd_en,
  input  logic [VCW-1:0]       rd_vc,
  output logic [NUM_BITS-1:0]  fifo_out,
  output logic                 rd_valid,
  output logic [VCW-1:0]       rd_vc_out,
  output logic [NUM_VC-1:0]    empty,
  output logic [NUM_VC-1:0]    full,
  output logic [NUM_VC-1:0]    almost_full,
  output logic [NUM_VC*CW-1:0] fifo_counter,
  output logic [NUM_VC-1:0]    credit_out,
  output logic [NUM_VC-1:0]    err_ovf,
  output logic [NUM_VC-1:0]    err_udf,
  input  logic                 err_clr
);
  logic [NUM_BITS-1:0] mem [NUM_VC*DEPTH];
  logic [PW-1:0] wr_ptr [NUM_VC];
  logic [PW-1:0] rd_ptr [NUM_VC];
  logic [NUM_VC-1:0] wr_acc, rd_acc;
  for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
    vc_fifo_ctrl #(.DEPTH(DEPTH), .AF_LEVEL(AF_LEVEL), .PW(PW), .CW(CW)) u_ctrl (
      .clk(clk),
      .rst_n(rst_n),
      .wr_req(wr_en && wr_vc == VCW'(v)),
      .rd_req(rd_en && rd_vc == VCW'(v)),
      .err_clr(err_clr),
      .wr_acc(wr_acc[v]),
      .rd_acc(rd_acc[v]),
      .wr_ptr(wr_ptr[v]),
      .rd_ptr(rd_ptr[v]),
      .count(fifo_counter[v*CW +: CW]),
      .empty(empty[v]),
      .full(full[v]),
      .almost_full(almost_full[v]),
      .err_ovf(err_ovf[v]),
      .err_udf(err_udf[v])
    );
  end
  // storage is addressed {vc, ptr} and deliberately left unreset
  always_ff @(posedge clk) begin
    if (|wr_acc) mem[{wr_vc, wr_ptr[wr_vc]}] <= fifo_in;
  end
  // read register holds its last flit when no read is accepted; credit mirrors the accepted VC
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      fifo_out <= '0;
      rd_valid <= 1'b0;
      rd_vc_out <= '0;
      credit_out <= '0;
    end else begin
      rd_valid <= |rd_acc;
      credit_out <= rd_acc;
      if (|rd_acc) begin
        fifo_out <= mem[{rd_vc, rd_ptr[rd_vc]}];
        rd_vc_out <= rd_vc;
      end
    end
  end
endmodule

// File: tb/tb_vc_input_buffer.sv
// tb_vc_input_buffer: randomized and directed checks against a queue-based model
module tb_vc_input_buffer;
  localparam int D = 8;
  localparam int NV = 4;
  logic clk = 0, rst_n = 1, wr_en = 0, rd_en = 0, err_clr = 0;
  logic [1:0] wr_vc = 0, rd_vc = 0;
  logic [15:0] fifo_in = 0;
  logic [15:0] fifo_out;
  logic rd_valid;
  logic [1:0] rd_vc_out;
  logic [3:0] empty, full, almost_full, credit_out, err_ovf, err_udf;
  logic [15:0] fifo_counter;
  int n_cmp = 0, n_bad = 0;

  vc_input_buffer #(.NUM_BITS(16), .DEPTH(D), .NUM_VC(NV), .AF_LEVEL(6)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_vc(wr_vc), .fifo_in(fifo_in),
    .rd_en(rd_en), .rd_vc(rd_vc), .fifo_out(fifo_out), .rd_valid(rd_valid),
    .rd_vc_out(rd_vc_out), .empty(empty), .full(full), .almost_full(almost_full),
    .fifo_counter(fifo_counter), .credit_out(credit_out), .err_ovf(err_ovf),
    .err_udf(err_udf), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  logic [15:0] mq [NV][$];
  logic [15:0] m_out = 0;
  logic m_val = 0;
  logic [1:0] m_vc = 0;
  logic [3:0] m_cred = 0, m_ovf = 0, m_udf = 0;
  bit wa, ra;

  always @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      for (int v = 0; v < NV; v++) mq[v].delete();
      m_out = 0; m_val = 0; m_vc = 0; m_cred = 0; m_ovf = 0; m_udf = 0;
    end else begin
      if (err_clr) begin m_ovf = 0; m_udf = 0; end
      if (wr_en && mq[wr_vc].size() == D) m_ovf[wr_vc] = 1;
      if (rd_en && mq[rd_vc].size() == 0) m_udf[rd_vc] = 1;
      wa = wr_en && mq[wr_vc].size() < D;
      ra = rd_en && mq[rd_vc].size() > 0;
      m_val = ra;
      m_cred = 0;
      if (ra) begin
        m_out = mq[rd_vc].pop_front();
        m_vc = rd_vc;
        m_cred[rd_vc] = 1;
      end
      if (wa) mq[wr_vc].push_back(fifo_in);
    end
  end

  logic [3:0] e_emp, e_full, e_af;
  logic [15:0] e_cnt;
  always @(negedge clk) begin
    for (int v = 0; v < NV; v++) begin
      e_emp[v] = mq[v].size() == 0;
      e_full[v] = mq[v].size() == D;
      e_af[v] = mq[v].size() >= 6;
      e_cnt[v*4 +: 4] = 4'(mq[v].size());
    end
    chk("empty", 32'(empty), 32'(e_emp));
    chk("full", 32'(full), 32'(e_full));
    chk("almost_full", 32'(almost_full), 32'(e_af));
    chk("fifo_counter", 32'(fifo_counter), 32'(e_cnt));
    chk("rd_valid", 32'(rd_valid), 32'(m_val));
    chk("fifo_out", 32'(fifo_out), 32'(m_out));
    chk("rd_vc_out", 32'(rd_vc_out), 32'(m_vc));
    chk("credit_out", 32'(credit_out), 32'(m_cred));
    chk("err_ovf", 32'(err_ovf), 32'(m_ovf));
    chk("err_udf", 32'(err_udf), 32'(m_udf));
  end

  task automatic drive(input bit we, input logic [1:0] wv, input logic [15:0] d,
                       input bit re, input logic [1:0] rv, input bit clr);
    @(posedge clk);
    #2;
    wr_en = we; wr_vc = wv; fifo_in = d; rd_en = re; rd_vc = rv; err_clr = clr;
  endtask

  task automatic idle_look();
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #2 rst_n = 0;
    @(negedge clk); #1;
    chk("rst empty", 32'(empty), 32'hF);
    chk("rst counter", 32'(fifo_counter), 0);
    chk("rst fifo_out", 32'(fifo_out), 0);
    chk("rst rd_valid", 32'(rd_valid), 0);
    for (int i = 1; i <= 8; i++) drive(1, 2, 16'(i), 0, 0, 0);
    idle_look();
    chk("vc2 full", 32'(full[2]), 1);
    chk("vc2 af", 32'(almost_full[2]), 1);
    chk("vc2 count8", 32'(fifo_counter[8 +: 4]), 8);
    drive(1, 2, 16'd9, 0, 0, 0);
    idle_look();
    chk("vc2 ovf", 32'(err_ovf[2]), 1);
    chk("vc2 still8", 32'(fifo_counter[8 +: 4]), 8);
    for (int i = 1; i <= 8; i++) begin
      drive(0, 0, 0, 1, 2, 0);
      idle_look();
      chk("vc2 data", 32'(fifo_out), 32'(i));
      chk("vc2 valid", 32'(rd_valid), 1);
      chk("vc2 vcout", 32'(rd_vc_out), 2);
      chk("vc2 credit", 32'(credit_out), 32'h4);
    end
    drive(0, 0, 0, 0, 0, 1);
    drive(1, 0, 16'h00A0, 0, 0, 0);
    drive(1, 3, 16'h00B3, 0, 0, 0);
    drive(0, 0, 0, 1, 3, 0);
    idle_look();
    chk("ilv b3", 32'(fifo_out), 32'hB3);
    drive(0, 0, 0, 1, 0, 0);
    idle_look();
    chk("ilv a0", 32'(fifo_out), 32'hA0);
    chk("ilv counts", 32'(fifo_counter), 0);
    for (int i = 1; i <= 3; i++) drive(1, 1, 16'(16'h10 + i), 0, 0, 0);
    for (int i = 0; i < 10; i++) drive(1, 1, 16'(16'h20 + i), 1, 1, 0);
    idle_look();
    chk("vc1 steady", 32'(fifo_counter[4 +: 4]), 3);
    drive(0, 0, 0, 1, 1, 0);
    idle_look();
    chk("vc1 wrap data", 32'(fifo_out), 32'h27);
    drive(1, 0, 16'h0055, 1, 0, 0);
    idle_look();
    chk("udf set", 32'(err_udf[0]), 1);
    chk("udf rd_valid", 32'(rd_valid), 0);
    chk("udf count", 32'(fifo_counter[0 +: 4]), 1);
    drive(0, 0, 0, 0, 0, 1);
    idle_look();
    chk("udf clr", 32'(err_udf), 0);
    for (int i = 0; i < 5; i++) drive(1, 2, 16'(16'h60 + i), 0, 0, 0);
    @(posedge clk);
    #2;
    wr_en = 0;
    rst_n = 1;
    #1;
    chk("arst count", 32'(fifo_counter[8 +: 4]), 0);
    chk("arst empty", 32'(empty[2]), 1);
    chk("arst valid", 32'(rd_valid), 0);
    @(posedge clk);
    #2 rst_n = 0;
    drive(0, 0, 0, 1, 2, 0);
    idle_look();
    chk("post rst read", 32'(rd_valid), 0);
    chk("post rst udf", 32'(err_udf[2]), 1);
    for (int i = 0; i < 600; i++) begin
      @(posedge clk);
      #2;
      rst_n = i == 300;
      wr_en = $urandom_range(0, 9) < 7;
      wr_vc = 2'($urandom_range(0, 3));
      fifo_in = 16'($urandom);
      rd_en = $urandom_range(0, 9) < 5;
      rd_vc = 2'($urandom_range(0, 3));
      err_clr = $urandom_range(0, 19) == 0;
    end
    idle_look();
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/vc_input_buffer.md
Name: vc_input_buffer

Overview:
- Parametrised multi-virtual-channel input buffer for a torus router port. Successor to the single-channel local-port FIFO.
- Holds NUM_VC independent FIFOs of DEPTH flits each. Shares one write port (VC-tagged) and one read port (VC-selected).
- Adds registered read-valid, per-VC almost-full, per-VC credit return and sticky overflow/underflow error flags.
- Sits between the link receiver (writes) and the switch allocator/crossbar (reads).

Parameters:
- NUM_BITS, 16, flit width in bits.
- DEPTH, 8, flits per VC; power of two, >= 2.
- NUM_VC, 4, number of virtual channels; power of two, >= 1.
- AF_LEVEL, DEPTH-2, almost_full asserts when a VC's count >= AF_LEVEL.
- Derived: VCW = max(1, clog2(NUM_VC)), PW = clog2(DEPTH), CW = clog2(DEPTH)+1.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst_n  in  1  asynchronous, active-high reset (name kept per codebase).
- wr_en  in  1  write request.
- wr_vc  in  VCW  target VC for write.
- fifo_in  in  NUM_BITS  write flit.
- rd_en  in  1  read request.
- rd_vc  in  VCW  source VC for read.
- fifo_out  out  NUM_BITS  registered read flit.
- rd_valid  out  1  fifo_out was loaded this cycle.
- rd_vc_out  out  VCW  VC that fifo_out came from.
- empty  out  NUM_VC  per-VC empty, combinational from count.
- full  out  NUM_VC  per-VC full (count == DEPTH).
- almost_full  out  NUM_VC  per-VC count >= AF_LEVEL.
- fifo_counter  out  NUM_VC*CW  packed per-VC occupancy; VC i occupies bits [i*CW +: CW].
- credit_out  out  NUM_VC  one-cycle pulse per accepted read, to the upstream credit counter.
- err_ovf  out  NUM_VC  sticky: a write was attempted while full.
- err_udf  out  NUM_VC  sticky: a read was attempted while empty.
- err_clr  in  1  synchronous clear of err_ovf and err_udf.

Behaviour:
- Reset (async, rst_n=1):
  - all counts and pointers go to 0; empty=all 1s; full, almost_full = 0.
  - fifo_out=0, rd_valid=0, rd_vc_out=0, credit_out=0, err_* = 0.
  - Memory contents are not reset.
  - Reset asserted mid-operation discards all stored flits immediately.
- Write acceptance: wr_acc = wr_en && !full[wr_vc]. On wr_acc, mem[wr_vc][wr_ptr] <= fifo_in and wr_ptr[wr_vc] increments.
  - No write-through when full: a write to a full VC is rejected even if the same VC is read that cycle.
- Read acceptance: rd_acc = rd_en && !empty[rd_vc]. On rd_acc:
  - fifo_out <= mem[rd_vc][rd_ptr] and rd_ptr[rd_vc] increments;
  - rd_vc_out <= rd_vc, rd_valid <= 1, credit_out[rd_vc] <= 1 (all next cycle);
  - otherwise rd_valid and credit_out are 0 next cycle, and fifo_out and rd_vc_out hold.
- Latency:
  - read data is valid 1 cycle after the accepted request;
  - a flit written in cycle N is readable by a request in cycle N+1;
  - there is no fall-through: a read of an empty VC is rejected even if the same VC is written that cycle.
- Count update per VC, evaluated independently:
  - +1 if write accepted on it only;
  - -1 if read accepted on it only;
  - unchanged if both or neither.
  - Write and read on different VCs in the same cycle both proceed.
- Pointers are PW bits and wrap DEPTH-1 -> 0 naturally. The count is CW bits and ranges 0..DEPTH.
- Errors and clearing:
  - wr_en && full[wr_vc] sets err_ovf[wr_vc].
  - rd_en && empty[rd_vc] sets err_udf[rd_vc].
  - err_clr clears all error bits; a set event in the same cycle as err_clr wins.
- No FSM is needed beyond the per-VC counter/pointer state; all control is registered in the single clock domain.

Decomposition:
- Shared package noc_buf_pkg holds:
  - the clog2 function;
  - the VCW/PW/CW derivation rules;
  - the flit width default.
- Sub-module vc_fifo_ctrl holds per-VC count, pointers, empty/full/almost_full and error bits. It is instantiated NUM_VC times via generate.
- The top level owns the shared storage array (NUM_VC*DEPTH entries, index {vc, ptr}), the read-output register and the accept decode.

Test Plan (NUM_BITS=16, DEPTH=8, NUM_VC=4, AF_LEVEL=6):
- Reset then idle -> empty=4'b1111, full=0, fifo_counter=0, fifo_out=0, rd_valid=0.
- Write 8'h?? values 1..8 to VC2, then a 9th write of 9 -> full[2]=1 after 8 writes, almost_full[2]=1 from count 6, 9th rejected, err_ovf[2]=1. Eight reads of VC2 return 1..8 in order, each with rd_valid=1, rd_vc_out=2 and a credit_out[2] pulse one cycle later.
- Interleaved: write VC0=0xA0, write VC3=0xB3, read VC3, read VC0 -> fifo_out 0xB3 then 0xA0. Counts return to 0, with no cross-VC disturbance.
- VC1 holding 3 flits, simultaneous write and read on VC1 for 10 cycles -> fifo_counter[VC1] stays 3. Data remains in FIFO order across pointer wrap.
- Simultaneous write to an empty VC0 and read of VC0 -> read rejected, err_udf[0]=1, count becomes 1, rd_valid=0. Then assert err_clr -> err_udf=0.
- Reset asserted mid-stream with VC2 count=5 -> immediately count=0, empty[2]=1, rd_valid=0. The next read of VC2 is rejected.
